// File: rtl/otter_mem_arbiter_pkg.sv
// Shared types and constants for the OTTER memory/IO bus arbiter.
package otter_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} arb_state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/otter_mem_arbiter_watchdog.sv
// Bus watchdog: counts busy cycles without an ack and pulses timeout on the
// TIMEOUT-th such cycle. TIMEOUT=0 removes the counter entirely.
module otter_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign timeout = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Fires in the cycle the count would reach TIMEOUT.
            assign timeout = en && (cnt == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/otter_mem_arbiter.sv
// Arbitrates the OTTER IF and MEM requesters onto a single bus port, one
// transaction at a time. Optional IF anti-starvation: OTTER_ARB_STARVE_GUARD_EN.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter int MAX_STARVE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [DATA_W/8-1:0]   mem_be,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_gnt,
    output logic                  mem_rvalid,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_err,
    output logic                  if_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

    arb_state_t state;
    owner_t     owner;
    logic       idle;
    logic       if_win;
    logic       mem_win;
    logic       if_forced;
    logic       wd_timeout;

    assign idle  = (state == IDLE);
    assign owner = (state == BUSY_MEM) ? OWN_MEM : OWN_IF;

`ifdef OTTER_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(MAX_STARVE + 1);
    logic [SW-1:0] starve_cnt;

    assign if_forced = (starve_cnt == SW'(MAX_STARVE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (if_win) begin
            starve_cnt <= '0;
        end else if (mem_win && if_req) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_max_starve;
    assign unused_max_starve = (MAX_STARVE == 0);
    assign if_forced = 1'b0;
`endif

    // Grants are combinational and only offered from IDLE outside reset.
    always_comb begin
        if_win  = 1'b0;
        mem_win = 1'b0;
        if (rst_n && idle) begin
            if (if_req && if_forced) begin
                if_win = 1'b1;
            end else if (mem_req) begin
                mem_win = 1'b1;
            end else if (if_req) begin
                if_win = 1'b1;
            end
        end
    end

    assign if_gnt  = if_win;
    assign mem_gnt = mem_win;

    otter_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (if_win || mem_win),
        .en      (!idle && !bus_ack),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_be     <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            if_rvalid  <= 1'b0;
            if_err     <= 1'b0;
            if_rdata   <= '0;
            mem_rvalid <= 1'b0;
            mem_err    <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            if_rvalid  <= 1'b0;
            if_err     <= 1'b0;
            mem_rvalid <= 1'b0;
            mem_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_win) begin
                        state     <= BUSY_MEM;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_we;
                        bus_be    <= mem_be;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                    end else if (if_win) begin
                        state     <= BUSY_IF;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_be    <= '1;
                        bus_addr  <= if_addr;
                        bus_wdata <= '0;
                    end
                end
                default: begin
                    // An ack in the timeout cycle wins: it is a normal completion.
                    if (bus_ack || wd_timeout) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        if (owner == OWN_MEM) begin
                            mem_rvalid <= 1'b1;
                            mem_err    <= !bus_ack;
                            mem_rdata  <= bus_ack ? bus_rdata : ERR_WORD;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_err    <= !bus_ack;
                            if_rdata  <= bus_ack ? bus_rdata : ERR_WORD;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter with a response scoreboard.
module tb_otter_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_be = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [31:0] mem_rdata;
    logic        bus_req, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata = '0;
    logic        man_ack = 1'b0;
    logic        auto_ack = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_mem;
        bit          err;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    assign bus_ack = auto_ack ? bus_req : man_ack;

    always #5 clk = ~clk;

    otter_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .MAX_STARVE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .if_err(if_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input bit is_mem, input bit err, input bit chk, input logic [31:0] d);
        exp_t e;
        e.is_mem = is_mem;
        e.err = err;
        e.chk_data = chk;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every rvalid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (if_rvalid || mem_rvalid) begin
            if (sbq.size() == 0) begin
                check("spurious_rvalid", {30'd0, if_rvalid, mem_rvalid}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rv_owner", {30'd0, if_rvalid, mem_rvalid}, e.is_mem ? 32'd1 : 32'd2);
                check("rv_err", e.is_mem ? mem_err : if_err, e.err);
                if (e.chk_data)
                    check("rv_rdata", e.is_mem ? mem_rdata : if_rdata, e.data);
            end
        end
    end

    initial begin
        int gcnt;
        bit exp_if;

        // Reset state
        #1;
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_be", bus_be, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_mem_rvalid", mem_rvalid, 0);
        cyc(); cyc();
        rst_n = 1'b1;

        // Single IF fetch, ack 3 cycles after bus_req rises
        cyc(); if_req = 1; if_addr = 32'h100; #1;
        check("t1_if_gnt", if_gnt, 1);
        check("t1_mem_gnt", mem_gnt, 0);
        cyc(); if_req = 0; #1;
        check("t1_bus_req", bus_req, 1);
        check("t1_bus_addr", bus_addr, 32'h100);
        check("t1_bus_be", bus_be, 4'hF);
        check("t1_bus_we", bus_we, 0);
        check("t1_no_gnt_busy", if_gnt, 0);
        cyc(); cyc(); cyc();
        check("t1_req_hold", bus_req, 1);
        man_ack = 1; bus_rdata = 32'h0000_0013;
        expect_rsp(0, 0, 1, 32'h0000_0013);
        cyc(); man_ack = 0; #1;
        check("t1_req_drop", bus_req, 0);

        // Simultaneous requests: MEM store first, IF at next IDLE
        cyc();
        if_req = 1; if_addr = 32'h200;
        mem_req = 1; mem_we = 1; mem_addr = 32'h1100_0000; mem_wdata = 32'hA5; mem_be = 4'h1;
        #1;
        check("t2_mem_gnt", mem_gnt, 1);
        check("t2_if_gnt_lose", if_gnt, 0);
        cyc(); mem_req = 0; mem_we = 0; #1;
        check("t2_bus_we", bus_we, 1);
        check("t2_bus_addr", bus_addr, 32'h1100_0000);
        check("t2_bus_wdata", bus_wdata, 32'hA5);
        check("t2_bus_be", bus_be, 4'h1);
        check("t2_if_wait", if_gnt, 0);
        man_ack = 1; bus_rdata = 32'h0;
        expect_rsp(1, 0, 0, 32'h0);
        cyc(); man_ack = 0; #1;
        check("t2_if_gnt_next", if_gnt, 1);
        cyc(); if_req = 0; #1;
        check("t2_if_bus_addr", bus_addr, 32'h200);
        check("t2_if_bus_we", bus_we, 0);
        check("t2_if_bus_be", bus_be, 4'hF);
        man_ack = 1; bus_rdata = 32'h55;
        expect_rsp(0, 0, 1, 32'h55);
        cyc(); man_ack = 0;

        // bus_ack while IDLE is ignored
        cyc(); man_ack = 1; #1;
        check("t_idle_ack_req", bus_req, 0);
        cyc(); man_ack = 0;
        cyc();

        // Back-to-back fetches with ack tied to bus_req
        cyc(); if_req = 1; if_addr = 32'h300; bus_rdata = 32'hC0DE_0000; auto_ack = 1;
        for (int k = 0; k < 4; k++) expect_rsp(0, 0, 1, 32'hC0DE_0000);
        gcnt = 0;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) cyc();
            if (i == 8) if_req = 0;
            #1;
            if (if_gnt) gcnt++;
            check("t3_gnt_pattern", if_gnt, (i < 8 && i % 2 == 0) ? 1 : 0);
            check("t3_rvalid_pattern", if_rvalid, (i >= 2 && i % 2 == 0) ? 1 : 0);
        end
        check("t3_gnt_count", gcnt, 4);
        cyc(); auto_ack = 0;

        // Watchdog timeout on a MEM load (TIMEOUT=8)
        cyc(); mem_req = 1; mem_we = 0; mem_addr = 32'h2000; mem_be = 4'hF; #1;
        check("t4_mem_gnt", mem_gnt, 1);
        expect_rsp(1, 1, 1, 32'hDEAD_BEEF);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 1) mem_req = 0;
            #1;
            check("t4_bus_req_high", bus_req, 1);
        end
        cyc();
        check("t4_bus_req_low", bus_req, 0);
        check("t4_mem_rvalid", mem_rvalid, 1);
        check("t4_mem_err", mem_err, 1);
        check("t4_mem_rdata", mem_rdata, 32'hDEAD_BEEF);

        // Reset during BUSY_MEM, pending IF granted after release
        cyc(); mem_req = 1; mem_we = 0; mem_addr = 32'h3000; #1;
        check("t5_mem_gnt", mem_gnt, 1);
        cyc(); mem_req = 0;
        cyc();
        check("t5_busy", bus_req, 1);
        if_req = 1; if_addr = 32'h400;
        #2 rst_n = 0;
        #1;
        check("t5_async_drop", bus_req, 0);
        check("t5_no_rvalid", mem_rvalid, 0);
        check("t5_gnt_in_reset", if_gnt, 0);
        cyc(); cyc();
        rst_n = 1; #1;
        check("t5_if_gnt_release", if_gnt, 1);
        cyc(); if_req = 0; #1;
        check("t5_bus_req", bus_req, 1);
        check("t5_bus_addr", bus_addr, 32'h400);
        man_ack = 1; bus_rdata = 32'h77;
        expect_rsp(0, 0, 1, 32'h77);
        cyc(); man_ack = 0;
        cyc();

        // Continuous MEM and IF requests: grant pattern
        cyc();
        mem_req = 1; mem_we = 0; mem_addr = 32'h5000; mem_be = 4'hF;
        if_req = 1; if_addr = 32'h600; bus_rdata = 32'hAB; auto_ack = 1;
        for (int g = 0; g < 10; g++) begin
            if (g > 0) begin
                cyc(); cyc();
            end
            #1;
`ifdef OTTER_ARB_STARVE_GUARD_EN
            exp_if = (g % 5 == 4);
`else
            exp_if = 1'b0;
`endif
            check("t6_if_gnt", if_gnt, exp_if);
            check("t6_mem_gnt", mem_gnt, !exp_if);
            expect_rsp(!exp_if, 0, 1, 32'hAB);
        end
        cyc(); cyc();
        mem_req = 0; if_req = 0; auto_ack = 0;
        cyc(); cyc();

        check("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares one memory/IO bus port between the pipeline's instruction-fetch requester (IF) and its load/store requester (MEM).
- Sits between the OTTER pipeline and the memory/IOBUS in the wrapper.
- Sequences one outstanding bus transaction at a time, with fixed MEM-over-IF priority and a bus watchdog timeout.
- Produces grant and response-valid pulses that the pipeline uses as stall releases.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, number of cycles to wait for bus_ack before aborting; 0 disables the watchdog.
- MAX_STARVE, 4, limit on consecutive MEM grants while IF waits (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  IF request; held high until if_gnt.
- if_addr  in  ADDR_W  IF fetch address.
- if_gnt  out  1  IF request accepted (pulse).
- if_rvalid  out  1  IF read data valid (pulse).
- if_rdata  out  DATA_W  IF read data.
- mem_req  in  1  MEM request; held high until mem_gnt.
- mem_we  in  1  1 = store, 0 = load.
- mem_be  in  DATA_W/8  byte enables.
- mem_addr  in  ADDR_W  MEM address.
- mem_wdata  in  DATA_W  store data.
- mem_gnt  out  1  MEM request accepted (pulse).
- mem_rvalid  out  1  MEM response valid (pulse); asserted for both loads and stores.
- mem_rdata  out  DATA_W  load data.
- mem_err  out  1  qualifies mem_rvalid: transaction timed out.
- if_err  out  1  qualifies if_rvalid: transaction timed out.
- bus_req  out  1  bus transaction active.
- bus_we  out  1  bus write.
- bus_be  out  DATA_W/8  bus byte enables.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_ack  in  1  single-cycle completion from the bus.
- bus_rdata  in  DATA_W  bus read data; valid while bus_ack is high.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0; bus_* payload registers 0.
  - Watchdog and starve counters 0.
  - An in-flight transaction is dropped immediately: bus_req falls asynchronously and no rvalid is issued.
- FSM states: IDLE, BUSY_IF, BUSY_MEM.
- IDLE:
  - if_gnt and mem_gnt are combinational in IDLE only.
  - mem_req has priority: mem_gnt=1 and next state BUSY_MEM.
  - Else, if if_req: if_gnt=1 and next state BUSY_IF.
  - On the grant edge, the winner's addr/we/be/wdata are registered onto bus_*. IF transactions use bus_we=0 and bus_be=all ones.
- BUSY_x:
  - bus_req=1 from the cycle after the grant and held until the bus_ack cycle inclusive.
  - The bus_* payload is stable for the whole transaction.
  - On bus_ack: bus_rdata is registered; the owner's rvalid is pulsed the next cycle with rdata valid, err=0; state returns to IDLE.
- Latency: grant at cycle N, bus_req from N+1, earliest ack at N+1, rvalid at N+2.
- A new grant may occur in the same cycle as the previous rvalid, because the FSM is in IDLE then. Back-to-back throughput is one transaction per 2 cycles.
- rdata holds its last value between pulses. Only the owner's rvalid pulses.
- Watchdog (TIMEOUT>0):
  - The counter increments each BUSY cycle without ack.
  - When it reaches TIMEOUT: bus_req drops, the owner gets rvalid=1 with err=1 and rdata=ERR_DATA (32'hDEAD_BEEF), and state returns to IDLE.
  - bus_ack arriving in the timeout cycle takes precedence (normal completion).
  - The counter clears on every grant.
- bus_ack seen while in IDLE is ignored.
- Requests arriving while BUSY are not granted; the requester holds its request.
- Simultaneous if_req and mem_req in IDLE: MEM wins; IF is granted at the next IDLE, unless another mem_req is present then.

Optional Feature:
- Macro: OTTER_ARB_STARVE_GUARD_EN.
- Defined:
  - A starve counter increments on each MEM grant made while if_req=1, and clears on any IF grant.
  - When the counter equals MAX_STARVE, IF wins the next IDLE arbitration even if mem_req=1.
- Undefined: strict MEM priority; the counter logic is absent.

Decomposition:
- Package otter_arb_pkg: arb_state_t enum {IDLE, BUSY_IF, BUSY_MEM}; owner_t enum {OWN_IF, OWN_MEM}; localparam ERR_DATA=32'hDEAD_BEEF.
- One sub-module: otter_arb_watchdog. It is a cycle counter with clear/enable inputs and a timeout pulse output, parameterised by TIMEOUT, and ties off when TIMEOUT=0.

Test Plan:
- Single IF fetch, if_addr=0x100, bus_ack 3 cycles after bus_req rises, bus_rdata=0x00000013 -> if_gnt at N, bus_addr=0x100 with bus_be=4'hF, if_rvalid with if_rdata=0x13, if_err=0.
- Simultaneous if_req and mem_req (store, addr 0x1100_0000, wdata 0xA5, be 4'h1) -> MEM is granted first with bus_we=1; IF is granted at the first IDLE after mem_rvalid.
- Back-to-back: bus_ack tied to bus_req, continuous if_req -> if_gnt every 2 cycles, if_rvalid every 2 cycles, 4 fetches in 8 cycles.
- TIMEOUT=8, bus_ack never asserted on a MEM load -> bus_req high exactly 8 cycles, then mem_rvalid=1, mem_err=1, mem_rdata=0xDEADBEEF; FSM returns to IDLE.
- rst_n pulled low 2 cycles into a BUSY_MEM transaction -> bus_req=0 immediately, no mem_rvalid; after release, a pending if_req is granted on the first clock edge.
- With OTTER_ARB_STARVE_GUARD_EN and MAX_STARVE=4, mem_req and if_req held continuously -> grant pattern MEM×4, IF, MEM×4, IF.
